// File: rtl/dma_read_checker.sv
// rtl/dma_read_checker.sv - pattern-checking DMA read engine: one host read per start, beat-by-beat pattern check
// Optional feature macro: DMA_RD_BACKPRESSURE_EN (read-data stall one cycle in four while in DATA)
module dma_read_checker #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 32,
  parameter int CNT_W  = 32
) (
  input  logic              pcie_clk,
  input  logic              pcie_aresetn,
  input  logic              ctrl_start,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [LEN_W-1:0]  ctrl_len,
  input  logic [31:0]       ctrl_offset,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [ADDR_W-1:0] m_cmd_address,
  output logic [LEN_W-1:0]  m_cmd_length,
  input  logic              s_data_valid,
  output logic              s_data_ready,
  input  logic [511:0]      s_data_data,
  input  logic [63:0]       s_data_keep,
  input  logic              s_data_last,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              last_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stray_cnt
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state, state_nxt;
  logic             start_r, start_rr;
  logic [31:0]      offset_q;
  logic [CNT_W-1:0] n_q;
  logic             req, len_bad, cmd_hs, beat_acc, beat_final, beat_end, beat_bad, stall;
  logic [31:0]      exp_word;
  logic             unused_keep;

  assign unused_keep = ^s_data_keep;

`ifdef DMA_RD_BACKPRESSURE_EN
  logic [1:0] bp_cnt;

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) bp_cnt <= 2'd0;
    else               bp_cnt <= bp_cnt + 2'd1;
  end

  assign stall = (bp_cnt == 2'd3);
`else
  assign stall = 1'b0;
`endif

  assign req          = start_r & ~start_rr & (state == IDLE);
  assign len_bad      = (ctrl_len == '0) || (ctrl_len[5:0] != 6'd0);
  assign s_data_ready = ~((state == DATA) & stall);
  assign cmd_hs       = m_cmd_valid & m_cmd_ready;
  assign beat_acc     = s_data_valid & s_data_ready;
  assign beat_final   = (beat_cnt == n_q - CNT_W'(1));
  // Expected word is the 32-bit wrapped sum of beat index and offset.
  assign exp_word     = 32'(beat_cnt) + offset_q;
  assign beat_bad     = (s_data_data != {480'd0, exp_word});
  assign beat_end     = (state == DATA) & beat_acc & (beat_final | s_data_last);
  assign busy         = (state != IDLE);

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    m_cmd_valid = 1'b0;
    case (state)
      IDLE: if (req && !len_bad) state_nxt = CMD;
      CMD: begin
        m_cmd_valid = 1'b1;
        if (m_cmd_ready) state_nxt = DATA;
      end
      DATA: if (beat_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      start_r       <= 1'b0;
      start_rr      <= 1'b0;
      done          <= 1'b0;
      len_err       <= 1'b0;
      last_err      <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '1;
      beat_cnt      <= '0;
      cycle_cnt     <= '0;
      stray_cnt     <= '0;
      m_cmd_address <= '0;
      m_cmd_length  <= '0;
      offset_q      <= '0;
      n_q           <= '0;
    end else begin
      start_r  <= ctrl_start;
      start_rr <= start_r;
      done     <= 1'b0;

      if (req) begin
        m_cmd_address <= ctrl_addr;
        m_cmd_length  <= ctrl_len;
        offset_q      <= ctrl_offset;
        n_q           <= CNT_W'(ctrl_len >> 6);
        if (len_bad) begin
          len_err <= 1'b1;
          done    <= 1'b1;
        end else begin
          len_err       <= 1'b0;
          last_err      <= 1'b0;
          err_cnt       <= '0;
          first_err_idx <= '1;
          beat_cnt      <= '0;
          cycle_cnt     <= '0;
        end
      end

      // The handshake cycle itself counts as the first transfer cycle.
      if (cmd_hs) cycle_cnt <= CNT_W'(1);

      if (state == DATA) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (beat_acc) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          if (beat_bad) begin
            if (err_cnt != ALL_ONES)       err_cnt       <= err_cnt + CNT_W'(1);
            if (first_err_idx == ALL_ONES) first_err_idx <= beat_cnt;
          end
          if (beat_final != s_data_last) last_err <= 1'b1;
          if (beat_end)                  done     <= 1'b1;
        end
      end else if (beat_acc && (stray_cnt != ALL_ONES)) begin
        stray_cnt <= stray_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_read_checker.sv
// tb/tb_dma_read_checker.sv - scoreboard testbench for dma_read_checker
`timescale 1ns/1ps
module tb_dma_read_checker;

  logic          pcie_clk = 1'b0;
  logic          pcie_aresetn;
  logic          ctrl_start;
  logic [63:0]   ctrl_addr;
  logic [31:0]   ctrl_len;
  logic [31:0]   ctrl_offset;
  logic          m_cmd_valid;
  logic          m_cmd_ready;
  logic [63:0]   m_cmd_address;
  logic [31:0]   m_cmd_length;
  logic          s_data_valid;
  logic          s_data_ready;
  logic [511:0]  s_data_data;
  logic [63:0]   s_data_keep;
  logic          s_data_last;
  logic          busy, done, len_err, last_err;
  logic [31:0]   err_cnt, first_err_idx, beat_cnt, cycle_cnt, stray_cnt;

  typedef struct packed {
    logic [31:0] err;
    logic [31:0] first;
    logic [31:0] beats;
    logic        last_err;
    logic        len_err;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hs_cnt   = 0;
  int   done_cnt = 0;
  int   exp_stray = 0;

  dma_read_checker #(.ADDR_W(64), .LEN_W(32), .CNT_W(32)) dut (
    .pcie_clk(pcie_clk), .pcie_aresetn(pcie_aresetn),
    .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr), .ctrl_len(ctrl_len), .ctrl_offset(ctrl_offset),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
    .s_data_keep(s_data_keep), .s_data_last(s_data_last),
    .busy(busy), .done(done), .len_err(len_err), .last_err(last_err),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .beat_cnt(beat_cnt),
    .cycle_cnt(cycle_cnt), .stray_cnt(stray_cnt)
  );

  always #5 pcie_clk = ~pcie_clk;

  // Inputs change only on negedges, so these are the values the next posedge will sample.
  always @(negedge pcie_clk) begin
    #1;
    if (m_cmd_valid && m_cmd_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(res_t r);
    return $sformatf("err=%0d first=%h beats=%0d last_err=%b len_err=%b",
                     r.err, r.first, r.beats, r.last_err, r.len_err);
  endfunction

  task automatic exec_run(input logic [63:0] a, input logic [31:0] l, input logic [31:0] off,
                          input int last_at, input int bad_at, input int stall,
                          output res_t got, output int lat, output int cyc,
                          output int cmd_bad, output bit ok);
    int n, sent, guard, i;
    logic acc;
    logic [31:0] w;
    res_t e;
    n    = int'(l >> 6);
    sent = (last_at >= 0 && last_at < n - 1) ? last_at + 1 : n;
    e.err      = (bad_at >= 0 && bad_at < sent) ? 32'd1 : 32'd0;
    e.first    = (bad_at >= 0 && bad_at < sent) ? 32'(bad_at) : 32'hFFFF_FFFF;
    e.beats    = 32'(sent);
    e.last_err = (last_at != n - 1);
    e.len_err  = 1'b0;
    exp_q.push_back(e);
    ok = 1; lat = 0; cyc = 0; cmd_bad = 0; got = '0;
    ctrl_addr = a; ctrl_len = l; ctrl_offset = off;
    m_cmd_ready = (stall == 0);
    ctrl_start = 1'b1;
    while (m_cmd_valid !== 1'b1 && lat < 10) begin
      @(negedge pcie_clk);
      lat++;
      if (lat == 1) ctrl_start = 1'b0;
    end
    ctrl_start = 1'b0;
    if (m_cmd_valid !== 1'b1) begin
      ok = 0;
      return;
    end
    for (int k = 0; k < stall; k++) begin
      ctrl_start   = ~ctrl_start;
      ctrl_addr    = {$urandom, $urandom};
      ctrl_len     = $urandom;
      s_data_valid = (k < 2);
      if (k < 2) exp_stray++;
      @(negedge pcie_clk);
      if (m_cmd_valid !== 1'b1 || m_cmd_address !== a || m_cmd_length !== l) cmd_bad++;
    end
    s_data_valid = 1'b0;
    ctrl_start   = 1'b0;
    m_cmd_ready  = 1'b1;
    @(negedge pcie_clk);
    if (m_cmd_valid !== 1'b0) cmd_bad++;
    cyc = 1; i = 0; guard = 0;
    while (i < sent && guard < 4 * n + 10) begin
      cyc++; guard++;
      w = 32'(i) + off + ((i == bad_at) ? 32'd1 : 32'd0);
      s_data_valid = 1'b1;
      s_data_data  = {480'd0, w};
      s_data_keep  = '1;
      s_data_last  = (i == last_at);
      acc = s_data_ready;
      @(negedge pcie_clk);
      if (acc) i++;
    end
    s_data_valid = 1'b0; s_data_last = 1'b0; s_data_data = '0;
    if (i < sent) ok = 0;
    if (done !== 1'b1 || busy !== 1'b0) ok = 0;
    got.err = err_cnt; got.first = first_err_idx; got.beats = beat_cnt;
    got.last_err = last_err; got.len_err = len_err;
  endtask

  task automatic test_reset;
    n_checks++;
    if ({m_cmd_valid, busy, done, len_err, last_err, s_data_ready} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000001", {m_cmd_valid, busy, done, len_err, last_err, s_data_ready});
    end
    n_checks++;
    if ({err_cnt, first_err_idx, beat_cnt, cycle_cnt, stray_cnt} !== {32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_counters: got err=%0d first=%h beats=%0d cyc=%0d stray=%0d required 0 ffffffff 0 0 0",
               err_cnt, first_err_idx, beat_cnt, cycle_cnt, stray_cnt);
    end
    @(negedge pcie_clk);
    pcie_aresetn = 1'b1;
    repeat (2) @(negedge pcie_clk);
    n_checks++;
    if ({m_cmd_valid, busy, done, s_data_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_idle: got %b required 0001", {m_cmd_valid, busy, done, s_data_ready});
    end
  endtask

  task automatic test_good_run;
    res_t got, e; int lat, cyc, cb, d0; bit ok;
    d0 = done_cnt;
    exec_run(64'h0000_1234_0000_0040, 32'd256, 32'h10, 3, -1, 0, got, lat, cyc, cb, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || cb != 0) begin n_fail++; $display("FAIL good_protocol: ok=%0d cmd_bad=%0d required ok=1 cmd_bad=0", ok, cb); end
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL good_status: got %s required %s", fmt(got), fmt(e)); end
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL good_cmd_latency: got %0d required 2", lat); end
    n_checks++;
    if (cycle_cnt !== 32'(cyc)) begin n_fail++; $display("FAIL good_cycle_cnt: got %0d required %0d", cycle_cnt, cyc); end
    repeat (2) @(negedge pcie_clk);
    n_checks++;
    if (done_cnt - d0 != 1 || done !== 1'b0) begin
      n_fail++; $display("FAIL good_done_pulse: got %0d pulses done=%b required 1 pulse done=0", done_cnt - d0, done);
    end
  endtask

  task automatic test_corrupt;
    res_t got, e; int lat, cyc, cb; bit ok;
    exec_run(64'h0000_0000_0001_0000, 32'd512, 32'h0, 7, 5, 0, got, lat, cyc, cb, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL corrupt_status: ok=%0d got %s required %s", ok, fmt(got), fmt(e)); end
    n_checks++;
    if (cycle_cnt !== 32'(cyc)) begin n_fail++; $display("FAIL corrupt_cycle_cnt: got %0d required %0d", cycle_cnt, cyc); end
    repeat (2) @(negedge pcie_clk);
  endtask

  task automatic test_early_last;
    res_t got, e; int lat, cyc, cb; bit ok;
    exec_run(64'h0000_0000_0002_0000, 32'd256, 32'h20, 1, -1, 0, got, lat, cyc, cb, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL early_last_status: ok=%0d got %s required %s", ok, fmt(got), fmt(e)); end
    @(negedge pcie_clk);
    n_checks++;
    if (busy !== 1'b0 || m_cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_last_idle: got busy=%b cmd_valid=%b required 0 0", busy, m_cmd_valid);
    end
    @(negedge pcie_clk);
  endtask

  task automatic test_bad_len;
    int h0, d0, vseen;
    logic [31:0] lens [2];
    lens[0] = 32'd100; lens[1] = 32'd0;
    h0 = hs_cnt; d0 = done_cnt; vseen = 0;
    foreach (lens[j]) begin
      ctrl_len = lens[j];
      ctrl_start = 1'b1;
      @(negedge pcie_clk);
      ctrl_start = 1'b0;
      @(negedge pcie_clk);
      n_checks++;
      if (done !== 1'b1 || len_err !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL bad_len_%0d: got done=%b len_err=%b busy=%b required 1 1 0", lens[j], done, len_err, busy);
      end
      repeat (4) begin
        @(negedge pcie_clk);
        if (m_cmd_valid !== 1'b0) vseen++;
      end
    end
    n_checks++;
    if (hs_cnt != h0 || vseen != 0) begin
      n_fail++; $display("FAIL bad_len_no_cmd: got %0d handshakes %0d valid cycles required 0 0", hs_cnt - h0, vseen);
    end
    n_checks++;
    if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL bad_len_done_cnt: got %0d required 2", done_cnt - d0); end
  endtask

  task automatic test_cmd_stall;
    res_t got, e; int lat, cyc, cb, h0; bit ok;
    h0 = hs_cnt;
    exec_run(64'hDEAD_BEEF_0000_1000, 32'd128, 32'h7, 1, -1, 10, got, lat, cyc, cb, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (cb != 0) begin n_fail++; $display("FAIL stall_cmd_stable: got %0d bad cycles required 0", cb); end
    repeat (3) @(negedge pcie_clk);
    n_checks++;
    if (hs_cnt - h0 != 1) begin n_fail++; $display("FAIL stall_one_cmd: got %0d handshakes required 1", hs_cnt - h0); end
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL stall_status: ok=%0d got %s required %s", ok, fmt(got), fmt(e)); end
    n_checks++;
    if (stray_cnt !== 32'(exp_stray)) begin n_fail++; $display("FAIL stall_stray_cnt: got %0d required %0d", stray_cnt, exp_stray); end
  endtask

  task automatic test_reset_mid_data;
    res_t got, e; int lat, cyc, cb, d0; bit ok;
    ctrl_addr = 64'h0000_0000_0003_0000; ctrl_len = 32'd512; ctrl_offset = 32'h0;
    m_cmd_ready = 1'b1; ctrl_start = 1'b1;
    @(negedge pcie_clk);
    ctrl_start = 1'b0;
    repeat (2) @(negedge pcie_clk);
    for (int i = 0; i < 3; i++) begin
      s_data_valid = 1'b1;
      s_data_data  = {480'd0, 32'(i)};
      @(negedge pcie_clk);
    end
    d0 = done_cnt;
    #3 pcie_aresetn = 1'b0;
    #1;
    exp_stray = 0;
    n_checks++;
    if ({m_cmd_valid, busy, done, len_err, last_err, s_data_ready} !== 6'b000001 ||
        {err_cnt, first_err_idx, beat_cnt, cycle_cnt, stray_cnt} !== {32'd0, 32'hFFFF_FFFF, 96'd0}) begin
      n_fail++;
      $display("FAIL midrun_reset: got flags=%b err=%0d first=%h beats=%0d cyc=%0d stray=%0d required 000001 0 ffffffff 0 0 0",
               {m_cmd_valid, busy, done, len_err, last_err, s_data_ready}, err_cnt, first_err_idx, beat_cnt, cycle_cnt, stray_cnt);
    end
    s_data_valid = 1'b0;
    @(negedge pcie_clk);
    pcie_aresetn = 1'b1;
    repeat (2) @(negedge pcie_clk);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_no_done: got %0d pulses busy=%b required 0 0", done_cnt - d0, busy);
    end
    exec_run(64'h0000_0000_0004_0000, 32'd192, 32'hFFFF_FFFE, 2, -1, 0, got, lat, cyc, cb, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin n_fail++; $display("FAIL wrap_status: ok=%0d got %s required %s", ok, fmt(got), fmt(e)); end
    repeat (2) @(negedge pcie_clk);
  endtask

  task automatic test_back_to_back;
    res_t got_a, got_b, e; int lat_a, lat_b, cyc, cb; bit ok_a, ok_b;
    for (int i = 0; i < 3; i++) begin
      s_data_valid = 1'b1;
      s_data_data  = {480'd0, $urandom};
      exp_stray++;
      @(negedge pcie_clk);
    end
    s_data_valid = 1'b0;
    @(negedge pcie_clk);
    n_checks++;
    if (stray_cnt !== 32'(exp_stray)) begin n_fail++; $display("FAIL idle_stray_cnt: got %0d required %0d", stray_cnt, exp_stray); end
    exec_run(64'h0000_0000_0005_0000, 32'd192, 32'h100, 2, 0, 0, got_a, lat_a, cyc, cb, ok_a);
    exec_run(64'h0000_0000_0006_0000, 32'd128, 32'h55, -1, -1, 0, got_b, lat_b, cyc, cb, ok_b);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok_a || got_a !== e) begin n_fail++; $display("FAIL b2b_first_status: ok=%0d got %s required %s", ok_a, fmt(got_a), fmt(e)); end
    e = exp_q.pop_front();
    n_checks++;
    if (!ok_b || got_b !== e) begin n_fail++; $display("FAIL b2b_second_status: ok=%0d got %s required %s", ok_b, fmt(got_b), fmt(e)); end
    n_checks++;
    if (lat_b != 2) begin n_fail++; $display("FAIL b2b_restart_latency: got %0d required 2", lat_b); end
    n_checks++;
    if (stray_cnt !== 32'(exp_stray)) begin n_fail++; $display("FAIL b2b_stray_hold: got %0d required %0d", stray_cnt, exp_stray); end
    repeat (2) @(negedge pcie_clk);
  endtask

  initial begin
    pcie_aresetn = 1'b0;
    ctrl_start   = 1'b0;
    ctrl_addr    = '0;
    ctrl_len     = '0;
    ctrl_offset  = '0;
    m_cmd_ready  = 1'b1;
    s_data_valid = 1'b0;
    s_data_data  = '0;
    s_data_keep  = '0;
    s_data_last  = 1'b0;
    repeat (3) @(negedge pcie_clk);
    test_reset();
    test_good_run();
    test_corrupt();
    test_early_last();
    test_bad_len();
    test_cmd_stall();
    test_reset_mid_data();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
